// File: rtl/router_pkg.sv
// Shared state encoding, limits and header packing for the router packet transmitter.
// Types and constants only; no timing or flow control of its own.
package router_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_HDR  = 3'd2,
      S_PAY  = 3'd3,
      S_PAR  = 3'd4,
      S_CHK  = 3'd5,
      S_GAP  = 3'd6
   } state_t;

   localparam int         MAX_LEN      = 63;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: synchronous write on the accepting edge, combinational read by send index.
// Zero read latency; no backpressure (the transmitter never writes and reads the same slot at once).
module router_tx_buf
   import router_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_we,
   input  logic [5:0] i_wr_idx,
   input  logic [7:0] i_wr_dat,
   input  logic [5:0] i_rd_idx,
   output logic [7:0] o_rd_dat
);

   logic [7:0] r_mem [0:MAX_LEN];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a whole packet, then sends header/payload/parity to the router and reports its error flag.
// Outputs registered (ready signals decoded from state); busy stalls any beat, pl_valid gaps stall loading.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int ERR_WAIT = 3,
   parameter int IFG      = 2
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_addr,
   input  logic [5:0] req_len,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic [7:0] pl_data,
   output logic [7:0] data_in,
   output logic       pkt_valid,
   input  logic       busy,
   input  logic       error,
   output logic       resp_valid,
   output logic       resp_err
);

   localparam logic [3:0] EW_LAST  = 4'(ERR_WAIT - 1);
   localparam logic [3:0] IFG_LAST = (IFG == 0) ? 4'd0 : 4'(IFG - 1);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_addr, w_addr_nxt;
   logic [5:0] r_len, w_len_nxt;
   logic [5:0] r_load_idx, w_load_idx_nxt;
   logic [5:0] r_send_idx, w_send_idx_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_par, w_par_nxt;
   logic       r_flag, w_flag_nxt;
   logic [7:0] r_data_in, w_data_nxt, w_rd_dat;
   logic       r_pkt_valid, r_resp_valid, r_resp_err;
   logic       w_load_fire, w_resp_nxt;

   assign req_ready   = rst && (r_state == S_IDLE);
   assign pl_ready    = (r_state == S_LOAD);
   assign w_load_fire = pl_valid && pl_ready;

   assign data_in    = r_data_in;
   assign pkt_valid  = r_pkt_valid;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;

   // Read with the next send index so the registered data_in already holds the upcoming byte.
   router_tx_buf u_buf (
      .i_clk    (clock),
      .i_we     (w_load_fire),
      .i_wr_idx (r_load_idx),
      .i_wr_dat (pl_data),
      .i_rd_idx (w_send_idx_nxt),
      .o_rd_dat (w_rd_dat)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_len_nxt      = r_len;
      w_load_idx_nxt = r_load_idx;
      w_send_idx_nxt = r_send_idx;
      w_cnt_nxt      = r_cnt;
      w_par_nxt      = r_par;
      w_flag_nxt     = r_flag;
      case (r_state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               w_addr_nxt     = req_addr;
               w_len_nxt      = req_len;
               w_par_nxt      = make_header(req_addr, req_len);
               w_load_idx_nxt = 6'd0;
               w_send_idx_nxt = 6'd0;
               w_flag_nxt     = 1'b0;
               if (req_len == 6'd0) begin
                  // Empty packets are rejected without touching the router.
                  w_state_nxt = S_CHK;
                  w_flag_nxt  = 1'b1;
                  w_cnt_nxt   = EW_LAST;
               end else begin
                  w_state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (w_load_fire) begin
               w_par_nxt      = r_par ^ pl_data;
               w_load_idx_nxt = r_load_idx + 6'd1;
               if (r_load_idx == r_len - 6'd1) begin
                  w_state_nxt = S_HDR;
               end
            end
         end
         S_HDR: begin
            if (!busy) begin
               w_state_nxt = S_PAY;
            end
         end
         S_PAY: begin
            if (!busy) begin
               if (r_send_idx == r_len - 6'd1) begin
                  w_state_nxt = S_PAR;
               end else begin
                  w_send_idx_nxt = r_send_idx + 6'd1;
               end
            end
         end
         S_PAR: begin
            if (!busy) begin
               w_state_nxt = S_CHK;
               w_cnt_nxt   = 4'd0;
            end
         end
         S_CHK: begin
            w_flag_nxt = r_flag | error;
            if (r_cnt == EW_LAST) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = (IFG == 0) ? S_IDLE : S_GAP;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == IFG_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Response is shown during the final CHK cycle, so it is registered on the edge entering it.
   assign w_resp_nxt = (w_state_nxt == S_CHK) && (w_cnt_nxt == EW_LAST);

   always_comb begin
      w_data_nxt = 8'd0;
      case (w_state_nxt)
         S_HDR:   w_data_nxt = make_header(r_addr, r_len);
         S_PAY:   w_data_nxt = w_rd_dat;
         S_PAR:   w_data_nxt = r_par;
         default: w_data_nxt = 8'd0;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_addr       <= 2'd0;
         r_len        <= 6'd0;
         r_load_idx   <= 6'd0;
         r_send_idx   <= 6'd0;
         r_cnt        <= 4'd0;
         r_par        <= 8'd0;
         r_flag       <= 1'b0;
         r_data_in    <= 8'd0;
         r_pkt_valid  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_len        <= w_len_nxt;
         r_load_idx   <= w_load_idx_nxt;
         r_send_idx   <= w_send_idx_nxt;
         r_cnt        <= w_cnt_nxt;
         r_par        <= w_par_nxt;
         r_flag       <= w_flag_nxt;
         r_data_in    <= w_data_nxt;
         r_pkt_valid  <= (w_state_nxt == S_HDR) || (w_state_nxt == S_PAY);
         r_resp_valid <= w_resp_nxt;
         r_resp_err   <= w_resp_nxt && w_flag_nxt;
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table vectors, reset abort, and random packets against a beat-list model.
module tb_router_pkt_tx;

   localparam int EW   = 3;
   localparam int GAPN = 2;

   logic       clock, rst;
   logic       req_valid, req_ready;
   logic [1:0] req_addr;
   logic [5:0] req_len;
   logic       pl_valid, pl_ready;
   logic [7:0] pl_data, data_in;
   logic       pkt_valid, busy, error, resp_valid, resp_err;

   int n_chk;
   int n_pass;

   router_pkt_tx #(.ERR_WAIT(EW), .IFG(GAPN)) dut (
      .clock      (clock),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .pl_valid   (pl_valid),
      .pl_ready   (pl_ready),
      .pl_data    (pl_data),
      .data_in    (data_in),
      .pkt_valid  (pkt_valid),
      .busy       (busy),
      .error      (error),
      .resp_valid (resp_valid),
      .resp_err   (resp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [1:0] addr;
      int         len;
      logic [7:0] base;
      int         busy_beat;
      int         busy_n;
      int         err_at;
      logic [7:0] exp_hdr;
      bit         exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Beat list = header, payload, XOR parity; response expected on the ERR_WAIT-th cycle after parity.
   task automatic run_pkt(input string tag, input logic [1:0] addr, input int len,
                          input logic [7:0] base, input bit rnd, input int busy_beat,
                          input int busy_n, input int err_at, input logic [7:0] exp_hdr,
                          input bit exp_err, input int abort_beat);
      logic [7:0] beats[$];
      logic [7:0] par, b;
      int lat, nbusy, k, stall, i, guard;
      bit acc;
      par = exp_hdr;
      beats.push_back(exp_hdr);
      for (int n = 0; n < len; n++) begin
         b = rnd ? 8'($urandom) : 8'(base * (n + 1));
         beats.push_back(b);
         par ^= b;
      end
      beats.push_back(par);

      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = 6'(len);
      @(negedge clock);
      chk({tag, " req_ready"}, req_ready, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      nbusy = 0;

      if (len == 0) begin
         @(negedge clock);
         chk({tag, " len0 resp_valid"}, resp_valid, 1);
         chk({tag, " len0 resp_err"}, resp_err, exp_err);
         chk({tag, " len0 pkt_valid"}, pkt_valid, 0);
         @(posedge clock); #1;
      end else begin
         i = 0;
         guard = 0;
         while (i < len && guard < 1000) begin
            pl_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pl_data  = beats[i + 1];
            if (rnd) begin
               busy  = 1'($urandom_range(0, 1));
               error = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            if (pl_valid) chk({tag, " pl_ready"}, pl_ready, 1);
            acc = pl_valid && pl_ready;
            @(posedge clock); #1;
            lat++;
            guard++;
            if (acc) i++;
         end
         pl_valid = 1'b0;
         error = 1'b0;
         chk({tag, " bytes loaded"}, i, len);

         k = 0;
         stall = 0;
         guard = 0;
         while (k < len + 2 && guard < 2000) begin
            if (k == abort_beat) begin
               #2 rst = 1'b0;
               #1;
               chk({tag, " abort pkt_valid"}, pkt_valid, 0);
               chk({tag, " abort data_in"}, data_in, 0);
               chk({tag, " abort req_ready"}, req_ready, 0);
               @(negedge clock);
               rst = 1'b1;
               #1 chk({tag, " req_ready after release"}, req_ready, 1);
               repeat (3) begin
                  @(posedge clock); #1;
                  @(negedge clock);
                  chk({tag, " no resp after abort"}, resp_valid, 0);
                  chk({tag, " idle pkt_valid"}, pkt_valid, 0);
               end
               @(posedge clock); #1;
               busy = 1'b0;
               return;
            end
            busy = rnd ? ($urandom_range(0, 2) == 0) : (k == busy_beat && stall < busy_n);
            @(negedge clock);
            chk($sformatf("%s beat%0d data_in", tag, k), data_in, beats[k]);
            chk($sformatf("%s beat%0d pkt_valid", tag, k), pkt_valid, (k <= len));
            chk({tag, " early resp_valid"}, resp_valid, 0);
            @(posedge clock); #1;
            lat++;
            guard++;
            if (busy) begin
               stall++;
               nbusy++;
            end else begin
               k++;
               stall = 0;
            end
         end
         busy = 1'b0;
         chk({tag, " beats sent"}, k, len + 2);

         for (int j = 1; j <= EW; j++) begin
            error = (j == err_at);
            if (rnd) busy = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk($sformatf("%s chk%0d resp_valid", tag, j), resp_valid, (j == EW));
            if (j == EW) begin
               chk({tag, " resp_err"}, resp_err, exp_err);
               chk({tag, " chk data_in"}, data_in, 0);
               if (!rnd) chk({tag, " resp latency"}, lat, 2 * len + 1 + EW + nbusy);
            end
            @(posedge clock); #1;
            lat++;
         end
         error = 1'b0;
         busy = 1'b0;
      end

      for (int g = 0; g < GAPN; g++) begin
         @(negedge clock);
         chk($sformatf("%s gap%0d req_ready", tag, g), req_ready, 0);
         chk($sformatf("%s gap%0d resp_valid", tag, g), resp_valid, 0);
         @(posedge clock); #1;
      end
      @(negedge clock);
      chk({tag, " req_ready after gap"}, req_ready, 1);
      @(posedge clock); #1;
   endtask

   initial begin
      vec_t       vt[7];
      int         len, ea;
      logic [1:0] ad;
      logic [7:0] hdr;
      bit         ee;

      n_chk = 0;
      n_pass = 0;
      rst = 1'b0;
      req_valid = 1'b0;
      req_addr = 2'd0;
      req_len = 6'd0;
      pl_valid = 1'b0;
      pl_data = 8'd0;
      busy = 1'b0;
      error = 1'b0;

      vt[0] = '{2'd1, 3,  8'h11, -1, 0, -1, 8'h0D, 1'b0};
      vt[1] = '{2'd1, 3,  8'h11,  2, 2, -1, 8'h0D, 1'b0};
      vt[2] = '{2'd2, 0,  8'h00, -1, 0, -1, 8'h00, 1'b1};
      vt[3] = '{2'd1, 3,  8'h11, -1, 0,  2, 8'h0D, 1'b1};
      vt[4] = '{2'd3, 5,  8'h07, -1, 0,  1, 8'h17, 1'b1};
      vt[5] = '{2'd0, 63, 8'h01,  0, 1, -1, 8'hFC, 1'b0};
      vt[6] = '{2'd2, 1,  8'hA5,  2, 3, -1, 8'h06, 1'b0};

      #12;
      chk("reset data_in", data_in, 0);
      chk("reset pkt_valid", pkt_valid, 0);
      chk("reset req_ready", req_ready, 0);
      chk("reset pl_ready", pl_ready, 0);
      chk("reset resp_valid", resp_valid, 0);
      chk("reset resp_err", resp_err, 0);
      @(negedge clock);
      rst = 1'b1;
      #1 chk("req_ready after reset release", req_ready, 1);
      @(posedge clock); #1;

      for (int v = 0; v < 7; v++) begin
         run_pkt($sformatf("vec%0d", v), vt[v].addr, vt[v].len, vt[v].base, 1'b0,
                 vt[v].busy_beat, vt[v].busy_n, vt[v].err_at, vt[v].exp_hdr, vt[v].exp_err, -1);
      end

      run_pkt("abort", vt[0].addr, vt[0].len, vt[0].base, 1'b0, -1, 0, -1, vt[0].exp_hdr, 1'b0, 2);
      run_pkt("after_abort", vt[0].addr, vt[0].len, vt[0].base, 1'b0, -1, 0, -1, vt[0].exp_hdr, 1'b0, -1);

      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 7) == 0) len = 0;
         else if ($urandom_range(0, 3) == 0) len = 63;
         else len = $urandom_range(1, 63);
         ad  = 2'($urandom_range(0, 3));
         ea  = $urandom_range(0, EW);
         ee  = (len == 0) || (ea >= 1 && ea < EW);
         hdr = {6'(len), ad};
         run_pkt($sformatf("rnd%0d", r), ad, len, 8'h00, 1'b1, -1, 0,
                 (ea == 0) ? -1 : ea, hdr, ee, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
